// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo channel: FSM state encoding,
// frame geometry, rx->tx handshake codes and the parity helper.
package uart_pkg;

    // Both the receiver and the transmitter walk the same frame sequence.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // rx->tx handshake strobe codes
    localparam logic [1:0] TXEN_GOOD = 2'b01;
    localparam logic [1:0] TXEN_FERR = 2'b10;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] i_byte);
        return ^i_byte;
    endfunction

endpackage

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop input synchroniser, then a centre-sampling FSM that
// deserialises start / 8 data (LSB first) / even parity / stop.
// A good stop bit latches the byte and parity status and fires a GOOD strobe;
// a bad stop bit fires a FERR strobe and leaves the held byte alone.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_serial,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic [1:0]           o_tx_enable
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    uart_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_parity_err;
    logic [1:0]           r_tx_enable;

    logic                 w_rx;
    logic                 w_bit_done;
    uart_state_e          w_state_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [2:0]           w_bit_idx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_par_bit_next;
    logic                 w_good;
    logic                 w_ferr;

    assign w_rx       = r_sync2;
    assign w_bit_done = (r_cnt == BIT_END);

    // Two-flop synchroniser; resets to the idle-high line level so reset
    // release never looks like a start bit.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_serial;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state, bit-timing counter and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_par_bit <= w_par_bit_next;
        end
    end

    // Next-state logic: half a bit to the start-bit centre, then one full
    // bit time between every later sample.
    // NOTE: every output of this block gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_par_bit_next = r_par_bit;
        w_good         = 1'b0;
        w_ferr         = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next     = '0;
                w_bit_idx_next = '0;
                if (!w_rx) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_cnt == HALF_END) begin
                    w_cnt_next   = '0;
                    // A line back high at mid-start is a glitch, not a frame.
                    w_state_next = w_rx ? IDLE : DATA;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {w_rx, r_shift[DATA_BITS-1:1]};
                    // 3-bit index wraps 7->0 on the way out of DATA.
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = PAR;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            PAR: begin
                if (w_bit_done) begin
                    w_cnt_next     = '0;
                    w_par_bit_next = w_rx;
                    w_state_next   = STOP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                    w_good       = w_rx;
                    w_ferr       = !w_rx;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Result registers: byte and parity status update only on a good stop;
    // the handshake strobe is high for exactly the one cycle after the sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_parity_err <= 1'b0;
            r_tx_enable  <= 2'b00;
        end else begin
            if (w_good) begin
                r_data       <= r_shift;
                r_parity_err <= even_parity(r_shift) ^ r_par_bit;
            end
            if (w_good) begin
                r_tx_enable <= TXEN_GOOD;
            end else if (w_ferr) begin
                r_tx_enable <= TXEN_FERR;
            end else begin
                r_tx_enable <= 2'b00;
            end
        end
    end

    assign o_data       = r_data;
    assign o_parity_err = r_parity_err;
    assign o_tx_enable  = r_tx_enable;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: on a start strobe, captures a byte and sends
// start / 8 data (LSB first) / regenerated even parity / stop, each bit held
// for CLKS_PER_BIT cycles. The line is driven from a flop, idle high.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;

    logic                 w_bit_done;
    logic                 w_load;
    uart_state_e          w_state_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [2:0]           w_bit_idx_next;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_par_next;
    logic                 w_tx_next;

    assign w_bit_done = (r_cnt == BIT_END);

    // FSM state, counters, data shift register and the registered line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
        end
    end

    // Next-state logic; the next line level is decided together with the
    // transition so the start bit appears one edge after the strobe.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_par_next     = r_par;
        w_tx_next      = r_tx;
        w_load         = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next     = '0;
                w_bit_idx_next = '0;
                w_tx_next      = 1'b1;
                w_load         = i_start;
            end
            START: begin
                if (w_bit_done) begin
                    w_cnt_next   = '0;
                    w_state_next = DATA;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = PAR;
                        w_tx_next    = r_par;
                    end else begin
                        w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_next    = r_shift[1];
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            PAR: begin
                if (w_bit_done) begin
                    w_cnt_next   = '0;
                    w_state_next = STOP;
                    w_tx_next    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = IDLE;
                    w_tx_next      = 1'b1;
                    // The last stop cycle counts as idle: with back-to-back
                    // reception the next strobe lands exactly here.
                    w_load         = i_start;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase

        if (w_load) begin
            w_shift_next = i_data;
            w_par_next   = even_parity(i_data);
            w_cnt_next   = '0;
            w_state_next = START;
            w_tx_next    = 1'b0;
        end
    end

    assign o_tx = r_tx;

endmodule

// File: rtl/uart_transceiver.sv
// UART echo channel: every good frame received on `serial` is re-sent on
// `tx_out` with freshly generated even parity. Pure structural top.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial,
    output logic [DATA_BITS-1:0] trans,
    output logic                 parity,
    output logic                 tx_out,
    output logic [1:0]           tx_enable
);

    // Receive side: deserialise, check parity and stop, raise the handshake.
    uart_receiver #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_serial     (serial),
        .o_data       (trans),
        .o_parity_err (parity),
        .o_tx_enable  (tx_enable)
    );

    // Transmit side: echo the latched byte on each GOOD strobe.
    uart_transmitter #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_start (tx_enable[0]),
        .i_data  (trans),
        .o_tx    (tx_out)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: directed frames driven bit by bit, a frame-level
// model that predicts trans / parity / tx_enable / tx_out for every cycle,
// and literal checks at hand-computed cycles.
module tb_uart_transceiver;

    localparam int CPB    = 16;
    localparam int HALF   = CPB / 2;
    localparam int FRAME  = 11 * CPB;
    // serial driven in cycle f -> strobe visible in cycle f + RX_LAT:
    // 2 sync flops + 1 cycle to leave idle + half bit + 10 full bits.
    localparam int RX_LAT = 3 + HALF + 10 * CPB;
    localparam int MAXC   = 16384;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial;
    logic [7:0] trans;
    logic       parity;
    logic       tx_out;
    logic [1:0] tx_enable;

    uart_transceiver #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial    (serial),
        .trans     (trans),
        .parity    (parity),
        .tx_out    (tx_out),
        .tx_enable (tx_enable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        int         strobe;
        logic [7:0] data;
        logic       par;
        logic       stop;
    } rx_ev_t;

    rx_ev_t     ev_q[$];
    logic       exp_tx [MAXC];
    logic [7:0] m_trans  = 8'h00;
    logic       m_parity = 1'b0;
    logic [1:0] m_txen   = 2'b00;
    int         tx_free  = 0;

    // Expected line level for an echoed frame starting at cycle st.
    task automatic fill_echo(input int st, input logic [7:0] d);
        logic [10:0] bits;
        bits = {1'b1, ^d, d, 1'b0};
        for (int b = 0; b < 11; b++)
            for (int k = 0; k < CPB; k++)
                if (st + b * CPB + k < MAXC) exp_tx[st + b * CPB + k] = bits[b];
    endtask

    always @(negedge clk) begin : compare
        rx_ev_t ev;
        m_txen = 2'b00;
        if (rst) begin
            m_trans  = 8'h00;
            m_parity = 1'b0;
            tx_free  = 0;
            ev_q.delete();
            for (int i = cyc; i < MAXC; i++) exp_tx[i] = 1'b1;
        end else if (ev_q.size() > 0 && ev_q[0].strobe == cyc) begin
            ev = ev_q.pop_front();
            if (ev.stop) begin
                m_txen   = 2'b01;
                m_trans  = ev.data;
                m_parity = (^ev.data) ^ ev.par;
                if (cyc + 1 >= tx_free) begin
                    fill_echo(cyc + 1, ev.data);
                    tx_free = cyc + 1 + FRAME;
                end
            end else begin
                m_txen = 2'b10;
            end
        end
        if (cyc < MAXC) begin
            check("trans", trans, m_trans);
            check("parity", {7'b0, parity}, {7'b0, m_parity});
            check("tx_enable", {6'b0, tx_enable}, {6'b0, m_txen});
            check("tx_out", {7'b0, tx_out}, {7'b0, exp_tx[cyc]});
        end
    end

    // ---------------- stimulus helpers ----------------
    // All drivers start just after a rising edge.
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        rx_ev_t ev;
        ev.strobe = cyc + RX_LAT;
        ev.data   = d;
        ev.par    = p;
        ev.stop   = s;
        ev_q.push_back(ev);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic goto_neg(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    logic a5_bits [11];
    int   f;
    int   s;
    int   s2;

    initial begin
        for (int i = 0; i < MAXC; i++) exp_tx[i] = 1'b1;
        a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        serial = 1'b1;
        rst    = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_trans", trans, 8'h00);
        check("reset_parity", {7'b0, parity}, 8'h00);
        check("reset_tx_enable", {6'b0, tx_enable}, 8'h00);
        check("reset_tx_out", {7'b0, tx_out}, 8'h01);
        rst = 1'b0;
        idle(4);

        // Good frame 0xA5, parity 0
        f = cyc;
        s = f + RX_LAT;
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                goto_neg(s);
                check("a5_trans", trans, 8'hA5);
                check("a5_parity", {7'b0, parity}, 8'h00);
                check("a5_tx_enable", {6'b0, tx_enable}, 8'h01);
                goto_neg(s + 1);
                check("a5_tx_enable_one_cycle", {6'b0, tx_enable}, 8'h00);
                for (int b = 0; b < 11; b++) begin
                    goto_neg(s + 1 + b * CPB + HALF);
                    check($sformatf("a5_echo_bit%0d", b), {7'b0, tx_out}, {7'b0, a5_bits[b]});
                end
            end
        join
        align();
        idle(2 * CPB);

        // Parity error: 0x01 sent with parity bit 0
        f = cyc;
        s = f + RX_LAT;
        fork
            send_frame(8'h01, 1'b0, 1'b1);
            begin
                goto_neg(s);
                check("perr_trans", trans, 8'h01);
                check("perr_parity", {7'b0, parity}, 8'h01);
                check("perr_tx_enable", {6'b0, tx_enable}, 8'h01);
                goto_neg(s + 1 + 9 * CPB + HALF);
                check("perr_echo_parity_bit", {7'b0, tx_out}, 8'h01);
            end
        join
        align();
        idle(2 * CPB);

        // Framing error: 0x3C with stop = 0
        f = cyc;
        s = f + RX_LAT;
        fork
            begin
                send_frame(8'h3C, 1'b0, 1'b0);
                serial = 1'b1;
            end
            begin
                goto_neg(s);
                check("ferr_tx_enable", {6'b0, tx_enable}, 8'h02);
                check("ferr_trans_kept", trans, 8'h01);
                check("ferr_parity_kept", {7'b0, parity}, 8'h01);
                goto_neg(s + 1 + HALF);
                check("ferr_tx_idle", {7'b0, tx_out}, 8'h01);
            end
        join
        align();
        idle(2 * CPB);

        // Start glitch: line low for 4 cycles
        serial = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(2 * CPB);
        check("glitch_trans_kept", trans, 8'h01);

        // Back-to-back 0x55 then 0xAA
        f  = cyc;
        s  = f + RX_LAT;
        s2 = s + FRAME;
        fork
            begin
                send_frame(8'h55, 1'b0, 1'b1);
                send_frame(8'hAA, 1'b0, 1'b1);
            end
            begin
                goto_neg(s);
                check("b2b_first_trans", trans, 8'h55);
                goto_neg(s2);
                check("b2b_second_trans", trans, 8'hAA);
                check("b2b_second_tx_enable", {6'b0, tx_enable}, 8'h01);
                goto_neg(s2 + 1 + HALF);
                check("b2b_second_echo_start", {7'b0, tx_out}, 8'h00);
                goto_neg(s2 + 1 + 2 * CPB + HALF);
                check("b2b_second_echo_bit1", {7'b0, tx_out}, 8'h01);
            end
        join
        align();
        idle(FRAME + 2 * CPB);

        // Reset during transmit of 0xF0's echo (data bit 1 is a 0)
        f = cyc;
        s = f + RX_LAT;
        fork
            send_frame(8'hF0, 1'b0, 1'b1);
            begin
                goto_neg(s + 1 + 2 * CPB + HALF);
                check("pre_reset_tx_low", {7'b0, tx_out}, 8'h00);
            end
        join
        align();
        rst = 1'b1;
        #1;
        check("rst_tx_out_async", {7'b0, tx_out}, 8'h01);
        check("rst_trans", trans, 8'h00);
        check("rst_parity", {7'b0, parity}, 8'h00);
        check("rst_tx_enable", {6'b0, tx_enable}, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2 * CPB);

        // Normal frame after reset: 0x5A
        f = cyc;
        s = f + RX_LAT;
        fork
            send_frame(8'h5A, 1'b0, 1'b1);
            begin
                goto_neg(s);
                check("post_rst_trans", trans, 8'h5A);
                check("post_rst_tx_enable", {6'b0, tx_enable}, 8'h01);
                goto_neg(s + 1 + HALF);
                check("post_rst_echo_start", {7'b0, tx_out}, 8'h00);
            end
        join
        align();
        idle(FRAME + 2 * CPB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- 8-bit UART echo block: the receiver deserialises frames from `serial`, and the transmitter re-serialises each good frame onto `tx_out`.
- Frame format: 1 start (0), 8 data LSB first, 1 even-parity bit, 1 stop (1).
- Sits at the chip serial pins as a loopback/echo channel; received byte, parity status and the rx→tx handshake are exported for observation.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (integer ≥ 4, even).
- DATA_BITS, 8, data bits per frame (fixed at 8 for this revision).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial  input  1  asynchronous serial receive line, idle high.
- trans  output  8  last good received byte; also the transmitter's source data.
- parity  output  1  parity-error flag of the last completed frame (1 = error).
- tx_out  output  1  serial transmit line, idle high.
- tx_enable  output  2  rx→tx handshake: bit0 = 1-cycle "frame good, start tx" strobe; bit1 = 1-cycle "framing error" strobe.

Behaviour:
- Reset (async, active-high): trans=8'h00, parity=0, tx_enable=2'b00, tx_out=1, both FSMs in IDLE, all counters cleared. Reset mid-frame aborts both directions immediately; tx_out returns high asynchronously.
- Input sync: `serial` passes through a 2-flop synchroniser before any use; the 2-cycle delay is accepted.
- Receiver FSM: IDLE → START → DATA → PAR → STOP → IDLE.
  - IDLE: wait for synchronised line = 0.
  - START: count CLKS_PER_BIT/2. If the line is still 0, enter DATA. If it is 1 (glitch), return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles (bit centres), shifting LSB first, 8 samples.
  - PAR: sample the parity bit at its centre.
  - STOP: sample at the centre of the stop bit.
    - Stop=1: in that same cycle, latch trans and set parity = (XOR of data ^ parity bit). Assert tx_enable=2'b01 for exactly one clk.
    - Stop=0: trans and parity are unchanged; assert tx_enable=2'b10 for one clk.
    - Either way, return to IDLE. A new start bit is accepted from the next cycle.
- Parity-error frames still update trans and still pulse tx_enable[0]; the echo is sent with correctly regenerated parity.
- Transmitter FSM: IDLE → START → DATA → PAR → STOP → IDLE; each state lasts CLKS_PER_BIT cycles per bit.
  - IDLE: on tx_enable[0]=1, capture trans into a shift register. tx_out goes 0 (start bit) on the next clk edge, giving 1-cycle latency.
  - DATA: send 8 bits LSB first.
  - PAR: send the even-parity bit (XOR of the data byte).
  - STOP: send 1 for one bit time, then return to IDLE.
- A tx_enable[0] strobe while the transmitter is not IDLE is dropped. Frame lengths match, so continuous back-to-back reception echoes every frame.
- tx_out is registered, with no combinational path from serial.
- Counters are sized ceil(log2(CLKS_PER_BIT)) bits; the bit index is 3 bits and wraps 7→0 at the DATA exit.

Decomposition:
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PAR, STOP;
  - localparams: FRAME_BITS=11, TXEN_GOOD=2'b01, TXEN_FERR=2'b10.
- Two sub-modules, uart_receiver and uart_transmitter, instantiated in uart_transceiver with no other logic.

Test Plan:
- Reset mid-transmit: assert rst during tx DATA → tx_out=1 at once; trans=0x00, parity=0, tx_enable=0; the next frame works normally.
- Good frame: CLKS_PER_BIT=16, send 0xA5 with parity 0 → trans=0xA5, parity=0, a single-cycle tx_enable=01. tx_out then shows start, bits 1,0,1,0,0,1,0,1, parity 0, stop, each 16 cycles.
- Parity error: send 0x01 with parity bit 0 → trans=0x01, parity=1, tx_enable=01. The echo carries parity bit 1.
- Framing error: send 0x3C with stop=0 → tx_enable=10 pulse, trans keeps its previous value, tx_out stays high.
- Start glitch: serial low for 4 cycles → no state change, no tx_enable pulse.
- Back-to-back: frames 0x55 then 0xAA with no idle gap → both latched in order; tx_out echoes both frames with no bit lost.
